// File: rtl/spike_event_encoder.sv
// Spike event encoder for the two-neuron FHN core.
// Detects threshold crossings with hysteresis on v1/v2 at each update strobe,
// measures inter-spike intervals in strobe steps and queues {neuron, ISI}
// events in a FIFO with a registered head and a valid/ready drain.
module spike_event_encoder #(
    parameter int                DATA_W     = 18,
    parameter logic [DATA_W-1:0] THR_HI     = 18'h0_8000,
    parameter logic [DATA_W-1:0] THR_LO     = 18'h3_8000,
    parameter int                ISI_W      = 16,
    parameter int                FIFO_DEPTH = 8
) (
    input  logic                          CLOCK_50,
    input  logic                          reset,
    input  logic                          sample_valid,
    input  logic signed [DATA_W-1:0]      v1,
    input  logic signed [DATA_W-1:0]      v2,
    output logic                          spike1,
    output logic                          spike2,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic                          ev_neuron,
    output logic [ISI_W-1:0]              ev_isi,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EV_W  = ISI_W + 1;

    localparam logic [0:0] ST_ARMED = 1'b0;
    localparam logic [0:0] ST_FIRED = 1'b1;

    localparam logic [ISI_W-1:0] ISI_MAX  = '1;
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

    logic [0:0]       st1_q, st1_d, st2_q, st2_d;
    logic [ISI_W-1:0] isi1_q, isi1_d, isi2_q, isi2_d;
    logic [ISI_W-1:0] isi1_inc, isi2_inc;
    logic             fire1, fire2;
    logic             spike1_q, spike2_q;
    logic             pend2_q, pend2_d;
    logic [ISI_W-1:0] pend2_isi_q, pend2_isi_d;

    logic [EV_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d, remain;
    logic             ovf_q, ovf_d;
    logic             ev_valid_q, ev_valid_d;
    logic [EV_W-1:0]  head_q, head_d;
    logic             wr_req, wr_acc, pop, full;
    logic [EV_W-1:0]  wr_data;

    // Per-channel hysteresis detectors and saturating ISI counters.
    always_comb begin
        isi1_inc = (isi1_q == ISI_MAX) ? isi1_q : isi1_q + 1'b1;
        isi2_inc = (isi2_q == ISI_MAX) ? isi2_q : isi2_q + 1'b1;
        fire1 = sample_valid && (st1_q == ST_ARMED) && (v1 >= $signed(THR_HI));
        fire2 = sample_valid && (st2_q == ST_ARMED) && (v2 >= $signed(THR_HI));
        st1_d  = st1_q;
        st2_d  = st2_q;
        isi1_d = isi1_q;
        isi2_d = isi2_q;
        if (sample_valid) begin
            if (fire1)
                st1_d = ST_FIRED;
            else if ((st1_q == ST_FIRED) && (v1 < $signed(THR_LO)))
                st1_d = ST_ARMED;
            if (fire2)
                st2_d = ST_FIRED;
            else if ((st2_q == ST_FIRED) && (v2 < $signed(THR_LO)))
                st2_d = ST_ARMED;
            isi1_d = fire1 ? '0 : isi1_inc;
            isi2_d = fire2 ? '0 : isi2_inc;
        end
    end

    // Single FIFO write port: a deferred neuron-2 event, else neuron 1, else neuron 2.
    // The deferred event can never collide with a new spike because strobes are
    // at least 3 cycles apart.
    always_comb begin
        wr_req      = pend2_q | fire1 | fire2;
        pend2_d     = fire1 & fire2;
        pend2_isi_d = (fire1 & fire2) ? isi2_inc : pend2_isi_q;
        if (pend2_q)
            wr_data = {1'b1, pend2_isi_q};
        else if (fire1)
            wr_data = {1'b0, isi1_inc};
        else
            wr_data = {1'b1, isi2_inc};
    end

    // FIFO bookkeeping; the head register is loaded from entries already stored
    // before this edge, so a write into an empty FIFO shows one cycle later.
    always_comb begin
        full       = (level_q == LVL_FULL);
        pop        = ev_valid_q & ev_ready;
        wr_acc     = wr_req & (~full | pop);
        ovf_d      = ovf_q | (wr_req & full & ~pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        level_d    = level_q + LVL_W'(wr_acc) - LVL_W'(pop);
        remain     = level_q - LVL_W'(pop);
        ev_valid_d = (remain != '0);
        head_d     = (remain != '0) ? mem[rd_ptr_d] : head_q;
    end

    // Event storage; contents are don't-care once reset clears the pointers.
    always_ff @(posedge CLOCK_50) begin
        if (!reset && wr_acc)
            mem[wr_ptr_q] <= wr_data;
    end

    // State registers with synchronous reset.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            st1_q       <= ST_ARMED;
            st2_q       <= ST_ARMED;
            isi1_q      <= '0;
            isi2_q      <= '0;
            spike1_q    <= 1'b0;
            spike2_q    <= 1'b0;
            pend2_q     <= 1'b0;
            pend2_isi_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ovf_q       <= 1'b0;
            ev_valid_q  <= 1'b0;
            head_q      <= '0;
        end else begin
            st1_q       <= st1_d;
            st2_q       <= st2_d;
            isi1_q      <= isi1_d;
            isi2_q      <= isi2_d;
            spike1_q    <= fire1;
            spike2_q    <= fire2;
            pend2_q     <= pend2_d;
            pend2_isi_q <= pend2_isi_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            ovf_q       <= ovf_d;
            ev_valid_q  <= ev_valid_d;
            head_q      <= head_d;
        end
    end

    assign spike1     = spike1_q;
    assign spike2     = spike2_q;
    assign ev_valid   = ev_valid_q;
    assign ev_neuron  = head_q[ISI_W];
    assign ev_isi     = head_q[ISI_W-1:0];
    assign fifo_level = level_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_spike_event_encoder.sv
// Directed bench for spike_event_encoder with a behavioural scoreboard.
module tb_spike_event_encoder;

    localparam int ISI_MAX = 65535;
    localparam int DEPTH   = 8;

    localparam logic signed [17:0] NEG87 = 18'sh3_2148;
    localparam logic signed [17:0] P75   = 18'sh0_C000;
    localparam logic signed [17:0] N75   = 18'sh3_4000;
    localparam logic signed [17:0] THLO  = 18'sh3_8000;
    localparam logic signed [17:0] THHI  = 18'sh0_8000;
    localparam logic signed [17:0] MID   = 18'sh0_4000;

    logic                CLOCK_50 = 1'b0;
    logic                reset = 1'b1;
    logic                sample_valid = 1'b0;
    logic signed [17:0]  v1 = '0;
    logic signed [17:0]  v2 = '0;
    logic                spike1, spike2, ev_valid, ev_neuron, overflow;
    logic                ev_ready = 1'b0;
    logic [15:0]         ev_isi;
    logic [3:0]          fifo_level;

    spike_event_encoder #(
        .DATA_W(18), .ISI_W(16), .FIFO_DEPTH(DEPTH)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .sample_valid(sample_valid),
        .v1(v1), .v2(v2), .spike1(spike1), .spike2(spike2),
        .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_neuron(ev_neuron),
        .ev_isi(ev_isi), .fifo_level(fifo_level), .overflow(overflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        bit n;
        int isi;
        int wedge;
    } ev_t;

    ev_t mq[$];
    int  n_assert = 0;
    int  n_fail   = 0;
    int  edge_no  = 0;
    bit  m_armed1, m_armed2, m_pend2, m_ovf, m_valid, m_spk1, m_spk2;
    int  m_cnt1, m_cnt2, m_pend2_isi;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_ev(input bit n, input int isi, input int e);
        ev_t t;
        t.n = n; t.isi = isi; t.wedge = e;
        if (mq.size() < DEPTH) mq.push_back(t);
        else m_ovf = 1'b1;
    endtask

    task automatic model_reset();
        mq.delete();
        m_armed1 = 1'b1; m_armed2 = 1'b1; m_pend2 = 1'b0; m_ovf = 1'b0;
        m_valid = 1'b0; m_cnt1 = 0; m_cnt2 = 0; m_pend2_isi = 0;
    endtask

    // One clock cycle: drive, advance the scoreboard model, then check outputs.
    task automatic step(input bit sv, input logic signed [17:0] a,
                        input logic signed [17:0] b, input bit rdy, input bit rst);
        int i1, i2;
        sample_valid = sv; v1 = a; v2 = b; ev_ready = rdy; reset = rst;
        edge_no++;
        m_spk1 = 1'b0; m_spk2 = 1'b0;
        if (rst) begin
            model_reset();
        end else begin
            if (m_valid && rdy) void'(mq.pop_front());
            if (m_pend2) begin
                push_ev(1'b1, m_pend2_isi, edge_no);
                m_pend2 = 1'b0;
            end
            if (sv) begin
                i1 = (m_cnt1 < ISI_MAX) ? m_cnt1 + 1 : ISI_MAX;
                i2 = (m_cnt2 < ISI_MAX) ? m_cnt2 + 1 : ISI_MAX;
                m_spk1 = m_armed1 && (a >= THHI);
                m_spk2 = m_armed2 && (b >= THHI);
                if (m_spk1) m_armed1 = 1'b0; else if (!m_armed1 && a < THLO) m_armed1 = 1'b1;
                if (m_spk2) m_armed2 = 1'b0; else if (!m_armed2 && b < THLO) m_armed2 = 1'b1;
                m_cnt1 = m_spk1 ? 0 : i1;
                m_cnt2 = m_spk2 ? 0 : i2;
                if (m_spk1) push_ev(1'b0, i1, edge_no);
                if (m_spk2) begin
                    if (m_spk1) begin
                        m_pend2 = 1'b1;
                        m_pend2_isi = i2;
                    end else begin
                        push_ev(1'b1, i2, edge_no);
                    end
                end
            end
            m_valid = (mq.size() > 0) && (mq[0].wedge <= edge_no - 1);
        end
        @(posedge CLOCK_50);
        #1;
        chk("spike1", 32'(spike1), 32'(m_spk1));
        chk("spike2", 32'(spike2), 32'(m_spk2));
        chk("ev_valid", 32'(ev_valid), 32'(m_valid));
        chk("fifo_level", 32'(fifo_level), 32'(mq.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        if (m_valid) begin
            chk("ev_neuron", 32'(ev_neuron), 32'(mq[0].n));
            chk("ev_isi", 32'(ev_isi), 32'(mq[0].isi));
        end
        if (rst) begin
            chk("rst_ev_neuron", 32'(ev_neuron), 32'd0);
            chk("rst_ev_isi", 32'(ev_isi), 32'd0);
        end
    endtask

    task automatic samp(input logic signed [17:0] a, input logic signed [17:0] b, input bit rdy);
        step(1'b1, a, b, rdy, 1'b0);
        step(1'b0, a, b, rdy, 1'b0);
        step(1'b0, a, b, rdy, 1'b0);
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, N75, N75, rdy, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b0, NEG87, NEG87, 1'b0, 1'b1);
        step(1'b0, NEG87, NEG87, 1'b0, 1'b1);
    endtask

    initial begin
        model_reset();

        // Sub-threshold hold: no activity.
        do_reset();
        for (int i = 0; i < 20; i++) samp(NEG87, NEG87, 1'b1);

        // First spike at sample 5, then periodic firing and threshold boundaries.
        do_reset();
        for (int i = 0; i < 4; i++) samp(NEG87, NEG87, 1'b1);
        samp(P75, NEG87, 1'b1);
        samp(P75, NEG87, 1'b1);
        samp(P75, NEG87, 1'b1);
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 7; i++) samp(N75, NEG87, 1'b1);
            for (int i = 0; i < 3; i++) samp(P75, NEG87, 1'b1);
        end
        samp(THLO, NEG87, 1'b1);
        samp(THLO, NEG87, 1'b1);
        samp(P75, NEG87, 1'b1);
        samp(N75, NEG87, 1'b1);
        samp(MID, NEG87, 1'b1);
        samp(THHI, NEG87, 1'b1);
        idle(3, 1'b1);

        // Simultaneous crossing with the consumer stalled.
        do_reset();
        for (int i = 0; i < 3; i++) samp(NEG87, NEG87, 1'b0);
        samp(P75, P75, 1'b0);
        idle(3, 1'b0);
        idle(5, 1'b1);

        // Ten spikes into an 8-deep FIFO, then drain.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            samp(P75, NEG87, 1'b0);
            for (int k = 0; k <= i % 3; k++) samp(N75, NEG87, 1'b0);
        end
        idle(2, 1'b0);
        idle(14, 1'b1);

        // Push and pop in the same cycle while full.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            samp(P75, NEG87, 1'b0);
            samp(N75, NEG87, 1'b0);
        end
        idle(2, 1'b0);
        step(1'b1, P75, NEG87, 1'b1, 1'b0);
        step(1'b0, P75, NEG87, 1'b0, 1'b0);
        step(1'b0, P75, NEG87, 1'b0, 1'b0);
        idle(14, 1'b1);

        // Reset while events are queued.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            samp(P75, NEG87, 1'b0);
            samp(N75, NEG87, 1'b0);
        end
        step(1'b1, P75, NEG87, 1'b0, 1'b1);
        samp(NEG87, NEG87, 1'b1);
        samp(NEG87, NEG87, 1'b1);
        samp(P75, NEG87, 1'b1);
        idle(4, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/spike_event_encoder.md
Name: spike_event_encoder

Overview:
- Sits directly downstream of the two-neuron FHN core.
- Samples both membrane potentials v1 and v2 on each neuron update strobe and detects spikes by threshold crossing with hysteresis.
- For each spike, measures the inter-spike interval (ISI) in update steps and queues {neuron id, ISI} events in a FIFO.
- The FIFO drains through a valid/ready handshake to the readout/display logic.

Parameters:
- DATA_W, 18: width of v1/v2, signed fixed point with 16 fractional bits.
- THR_HI, 18'h0_8000 (+0.5): fire threshold; spike when v >= THR_HI while armed.
- THR_LO, 18'h3_8000 (-0.5): re-arm threshold; re-arm when v < THR_LO.
- ISI_W, 16: ISI counter and event field width.
- FIFO_DEPTH, 8: event FIFO entries; must be a power of 2 and at least 2.

Ports:
- CLOCK_50, in, 1: system clock.
- reset, in, 1: synchronous, active-high reset.
- sample_valid, in, 1: one-cycle pulse when v1/v2 hold freshly updated values. Minimum spacing is 3 cycles.
- v1, in, DATA_W signed: neuron 1 membrane potential.
- v2, in, DATA_W signed: neuron 2 membrane potential.
- spike1, out, 1: one-cycle pulse on a neuron 1 spike.
- spike2, out, 1: one-cycle pulse on a neuron 2 spike.
- ev_valid, out, 1: FIFO head is valid.
- ev_ready, in, 1: consumer accepts the head.
- ev_neuron, out, 1: head neuron id (0 = neuron 1, 1 = neuron 2).
- ev_isi, out, ISI_W: head ISI, in sample_valid steps.
- fifo_level, out, clog2(FIFO_DEPTH)+1: current occupancy.
- overflow, out, 1: sticky flag; an event was dropped.

Behaviour:
- Reset (synchronous, checked every edge, overrides everything else):
  - Both channels go to ARMED and both ISI counters go to 0.
  - FIFO empty; pending flags cleared.
  - spike1/2 = 0, ev_valid = 0, ev_neuron = 0, ev_isi = 0, fifo_level = 0, overflow = 0.
  - A reset mid-operation discards queued events.
- Per-channel detector, evaluated only in cycles with sample_valid = 1 (signed compares):
  - ARMED and v >= THR_HI: spike. Go to FIRED, pulse spikeN at edge N+1 (N = sample_valid cycle), set pendingN.
  - FIRED and v < THR_LO: go to ARMED, no event.
  - Any other case: hold state.
  - v between THR_LO and THR_HI never causes a spike. A value exactly equal to THR_LO does not re-arm.
- ISI counter:
  - On every sample_valid, the counter increments, saturating at 2^ISI_W-1.
  - On a spike, the event ISI is the incremented value, and the counter is then cleared to 0 in the same edge.
  - The first spike after reset reports the number of samples since reset, including the spiking sample.
  - A saturated ISI reports as all-ones.
- FIFO write (single write port, one event per cycle):
  - pending1 is written at N+1.
  - pending2 is written at N+1 if pending1 is clear, otherwise at N+2.
  - When both channels spike in the same sample, neuron 1 is always enqueued first.
  - The 3-cycle minimum strobe spacing guarantees pending flags clear before the next sample.
- FIFO read:
  - The head is registered: ev_valid rises the cycle after the write into an empty FIFO.
  - Pop on ev_valid & ev_ready.
  - ev_neuron/ev_isi must stay stable while ev_valid & !ev_ready.
- Full:
  - A write while full with no pop in the same cycle drops the event and sets overflow (sticky until reset). The spike pulse still occurs.
  - A simultaneous pop and write while full is accepted with no overflow, and fifo_level stays at FIFO_DEPTH.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- Empty: ev_ready with ev_valid = 0 has no effect.
- fifo_level:
  - Updates at the same edge as the push/pop.
  - Simultaneous push and pop leaves it unchanged.

Test Plan:
- Reset, then hold v1 = 18'h3_2148 (-0.87) for 20 samples -> no spike1, ev_valid = 0, fifo_level = 0.
- v1 steps from -0.87 to 18'h0_C000 (+0.75) at sample 5, with ev_ready = 1 -> spike1 pulses 1 cycle after that strobe; ev_valid with ev_neuron = 0, ev_isi = 5 the next cycle, popped immediately.
- v1 oscillates: +0.75 for 3 samples, -0.75 for 7, repeating -> exactly one spike per period; second and later events have ev_isi = 10. A dip to exactly -0.5 followed by +0.75 gives no second spike.
- v1 and v2 both cross on the same strobe at sample 4, ev_ready = 0 -> two entries, neuron 0 first then neuron 1, both ev_isi = 4; fifo_level reaches 2 within 2 cycles of the strobe.
- ev_ready = 0 and 10 spikes generated with FIFO_DEPTH = 8 -> fifo_level = 8, overflow = 1. Drain 8 events: first-in order preserved, ISIs match, then ev_valid = 0. Push while popping at full -> no overflow change.
- Fill the FIFO with 3 events, assert reset for one cycle mid-stream -> next edge has ev_valid = 0, fifo_level = 0, overflow = 0, and the next spike reports its ISI counted from reset.
